// File: rtl/koa_pkg.sv
// Shared types and width helpers for the sequential Karatsuba multiplier.
package koa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        MID,
        CMB,
        DONE
    } koa_state_t;

    localparam int KOA_N_DEF  = 128;
    localparam int KOA_H_DEF  = KOA_N_DEF / 2;
    localparam int KOA_PW_DEF = 2 * KOA_H_DEF + 2;

    // Half operand width H for an N-bit operand.
    function automatic int koa_half(input int n);
        return n / 2;
    endfunction

    // Width of the shared product unit output: 2H+2.
    function automatic int koa_pw(input int n);
        return 2 * (n / 2) + 2;
    endfunction

endpackage

// File: rtl/koa_mult_core.sv
// Shared combinational product unit, sized for the (H+1)-bit middle term.
module koa_mult_core
    import koa_pkg::*;
#(
    parameter int WIDTH = KOA_H_DEF + 1
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/koa_multiplier_seq.sv
// Sequential Karatsuba multiplier: three partial products through one
// shared product unit, then a combine step; valid/ready on both sides.
module koa_multiplier_seq
    import koa_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   mult_a,
    input  logic [DATA_WIDTH-1:0]   mult_b,
    input  logic                    mult_signed,
    input  logic                    mult_valid_i,
    output logic                    mult_ready_o,
    output logic [2*DATA_WIDTH-1:0] mult_d,
    output logic                    mult_valid_o,
    input  logic                    mult_ready_i
);

    localparam int N  = DATA_WIDTH;
    localparam int H  = koa_half(N);
    localparam int PW = koa_pw(N);
    localparam int W  = H + 1;
    localparam int RW = 2 * N + 2;

    koa_state_t state_q, state_d;

    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic           sig_q, sig_d;
    logic           xs_q, xs_d;
    logic [2*H-1:0] plo_q, plo_d;
    logic [2*H-1:0] phi_q, phi_d;
    logic [PW-1:0]  pmid_q, pmid_d;
    logic [2*N-1:0] d_q, d_d;
    logic           v_q, v_d;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [PW-1:0]  prod;
    logic [RW-1:0]  r_full;
    logic [2*N-1:0] r_lo;
    logic           unused_carry;

    // Most negative value negates to itself, which is its correct magnitude.
    assign a_mag = (mult_signed && mult_a[N-1]) ? -mult_a : mult_a;
    assign b_mag = (mult_signed && mult_b[N-1]) ? -mult_b : mult_b;

    always_comb begin
        op_a = {1'b0, a_q[H-1:0]};
        op_b = {1'b0, b_q[H-1:0]};
        unique case (state_q)
            HI: begin
                op_a = {1'b0, a_q[N-1:H]};
                op_b = {1'b0, b_q[N-1:H]};
            end
            MID: begin
                op_a = {1'b0, a_q[H-1:0]} + {1'b0, a_q[N-1:H]};
                op_b = {1'b0, b_q[H-1:0]} + {1'b0, b_q[N-1:H]};
            end
            default: ;
        endcase
    end

    koa_mult_core #(
        .WIDTH(W)
    ) u_core (
        .a_i(op_a),
        .b_i(op_b),
        .p_o(prod)
    );

    // Two guard bits keep the middle-term subtraction exact.
    assign r_full = (RW'(phi_q) << N)
                  + ((RW'(pmid_q) - RW'(phi_q) - RW'(plo_q)) << H)
                  + RW'(plo_q);
    assign r_lo         = r_full[2*N-1:0];
    assign unused_carry = ^r_full[RW-1:2*N];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sig_d   = sig_q;
        xs_d    = xs_q;
        plo_d   = plo_q;
        phi_d   = phi_q;
        pmid_d  = pmid_q;
        d_d     = d_q;
        v_d     = v_q;
        unique case (state_q)
            IDLE: begin
                if (mult_valid_i) begin
                    state_d = LO;
                    a_d     = a_mag;
                    b_d     = b_mag;
                    sig_d   = mult_signed;
                    xs_d    = mult_a[N-1] ^ mult_b[N-1];
                end
            end
            LO: begin
                plo_d   = prod[2*H-1:0];
                state_d = HI;
            end
            HI: begin
                phi_d   = prod[2*H-1:0];
                state_d = MID;
            end
            MID: begin
                pmid_d  = prod;
                state_d = CMB;
            end
            CMB: begin
                d_d     = (sig_q && xs_q) ? -r_lo : r_lo;
                v_d     = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (mult_ready_i) begin
                    v_d     = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sig_q   <= 1'b0;
            xs_q    <= 1'b0;
            plo_q   <= '0;
            phi_q   <= '0;
            pmid_q  <= '0;
            d_q     <= '0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sig_q   <= sig_d;
            xs_q    <= xs_d;
            plo_q   <= plo_d;
            phi_q   <= phi_d;
            pmid_q  <= pmid_d;
            d_q     <= d_d;
            v_q     <= v_d;
        end
    end

    assign mult_ready_o = (state_q == IDLE);
    assign mult_d       = d_q;
    assign mult_valid_o = v_q;

endmodule

// File: tb/tb_koa_multiplier_seq.sv
// Bench for koa_multiplier_seq: N=16 and N=128 instances checked
// against a plain-arithmetic product model plus literal expectations.
module tb_koa_multiplier_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [1:0]        vi, ri, sg, vo, ro;
    logic [1:0][127:0] ai, bi;
    logic [1:0][255:0] dq;

    logic [31:0]  d16;
    logic [255:0] d128;
    logic         vo16, vo128, ro16, ro128;

    assign vo = {vo128, vo16};
    assign ro = {ro128, ro16};
    assign dq = {d128, {224'b0, d16}};

    koa_multiplier_seq #(.DATA_WIDTH(16)) u_d16 (
        .clk(clk),
        .rst(rst),
        .mult_a(ai[0][15:0]),
        .mult_b(bi[0][15:0]),
        .mult_signed(sg[0]),
        .mult_valid_i(vi[0]),
        .mult_ready_o(ro16),
        .mult_d(d16),
        .mult_valid_o(vo16),
        .mult_ready_i(ri[0])
    );

    koa_multiplier_seq #(.DATA_WIDTH(128)) u_d128 (
        .clk(clk),
        .rst(rst),
        .mult_a(ai[1]),
        .mult_b(bi[1]),
        .mult_signed(sg[1]),
        .mult_valid_i(vi[1]),
        .mult_ready_o(ro128),
        .mult_d(d128),
        .mult_valid_o(vo128),
        .mult_ready_i(ri[1])
    );

    // Reference: sign-extend to 2N bits when signed, multiply, keep 2N bits.
    function automatic logic [255:0] ref_mul(input logic [127:0] a,
                                             input logic [127:0] b,
                                             input logic s, input int n);
        logic [255:0] m, ea, eb, p;
        m  = {256{1'b1}} >> (256 - n);
        ea = {128'b0, a} & m;
        eb = {128'b0, b} & m;
        if (s && ea[n-1]) ea = ea | ~m;
        if (s && eb[n-1]) eb = eb | ~m;
        p = ea * eb;
        return p & ({256{1'b1}} >> (256 - 2 * n));
    endfunction

    function automatic logic [127:0] rnd_op(input int w);
        logic [127:0] one;
        one = 128'd1;
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return one << (w - 1);
            3: return (one << (w - 1)) - 128'd1;
            default: return {$urandom, $urandom, $urandom, $urandom};
        endcase
    endfunction

    task automatic chk(input bit ok, input string name,
                       input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [1:0]        pend, pv;
    logic [1:0][255:0] ex, pd;
    int                xc [2];

    task automatic mon_step();
        for (int d = 0; d < 2; d++) begin
            if (vo[d]) begin
                chk(ro[d] == 1'b0, "ready_o low while valid", ro[d], 0);
                if (!pv[d]) begin
                    chk(pend[d] == 1'b1, "output has a transaction",
                        pend[d], 1);
                    if (pend[d]) begin
                        chk(dq[d] == ex[d], "product vs model", dq[d], ex[d]);
                        chk(cyc - xc[d] == 4, "latency", cyc - xc[d], 4);
                    end
                end else begin
                    chk(dq[d] == pd[d], "mult_d stable", dq[d], pd[d]);
                end
            end else if (pend[d] && (cyc - xc[d] >= 4)) begin
                chk(1'b0, "product late", cyc - xc[d], 4);
                pend[d] = 1'b0;
            end
            pv[d] = vo[d] && !ri[d];
            pd[d] = dq[d];
            if (vo[d] && ri[d]) pend[d] = 1'b0;
            if (rst) begin
                pend[d] = 1'b0;
                pv[d]   = 1'b0;
            end else if (vi[d] && ro[d]) begin
                chk(pend[d] == 1'b0, "no overlapping transfer", pend[d], 0);
                pend[d] = 1'b1;
                ex[d]   = ref_mul(ai[d], bi[d], sg[d], d == 1 ? 128 : 16);
                xc[d]   = cyc + 1;
            end
        end
    endtask

    task automatic send(input int d, input logic [127:0] a,
                        input logic [127:0] b, input logic s);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        ai[d] = a;
        bi[d] = b;
        sg[d] = s;
        vi[d] = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!ro[d] && t < 20);
        if (!ro[d]) chk(1'b0, "ready_o timeout", t, 20);
        @(posedge clk);
        #1;
        vi[d] = 1'b0;
        ai[d] = {$urandom, $urandom, $urandom, $urandom};
        bi[d] = {$urandom, $urandom, $urandom, $urandom};
        sg[d] = ~s;
    endtask

    task automatic run_dir(input int d, input logic [127:0] a,
                           input logic [127:0] b, input logic s,
                           input logic [255:0] lit, input int hold,
                           input string name);
        int t;
        send(d, a, b, s);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!vo[d] && t < 10);
        if (!vo[d]) chk(1'b0, "valid_o timeout", t, 10);
        chk(dq[d] == lit, name, dq[d], lit);
        repeat (hold) begin
            @(negedge clk);
            chk(vo[d] && !ro[d], "held under back-pressure",
                {vo[d], ro[d]}, 2'b10);
        end
        @(posedge clk);
        #1 ri[d] = 1'b1;
        @(posedge clk);
        #1 ri[d] = 1'b0;
        @(negedge clk);
        chk(!vo[d] && ro[d], "idle after handshake", {vo[d], ro[d]}, 2'b01);
    endtask

    initial begin
        logic [127:0] ka, kb;
        logic [255:0] ones_sq;
        logic [1:0]   tx;
        int           left [2];
        int           gap [2];
        int           guard;

        rst  = 1'b1;
        vi   = '0;
        ri   = '0;
        sg   = '0;
        ai   = '0;
        bi   = '0;
        pend = '0;
        pv   = '0;
        ex   = '0;
        pd   = '0;

        chk(ref_mul(128'd3, 128'd5, 1'b0, 16) == 256'd15,
            "model 3*5", ref_mul(128'd3, 128'd5, 1'b0, 16), 15);
        chk(ref_mul(128'hFFFF, 128'h3, 1'b1, 16) == 256'hFFFF_FFFD,
            "model -1*3", ref_mul(128'hFFFF, 128'h3, 1'b1, 16),
            256'hFFFF_FFFD);

        repeat (3) @(posedge clk);
        #1;
        chk(vo == 2'b00, "reset valid_o", vo, 0);
        chk(dq == '0, "reset mult_d", dq[1] | dq[0], 0);
        rst = 1'b0;
        @(negedge clk);
        chk(ro == 2'b11, "ready_o after reset", ro, 2'b11);

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        ones_sq = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h1};
        run_dir(1, '1, '1, 1'b0, ones_sq, 0, "N128 all ones");
        run_dir(0, 128'h8000, 128'h8000, 1'b1, 256'h4000_0000, 0,
                "N16 min*min");
        run_dir(0, 128'h8000, 128'h0001, 1'b1, 256'hFFFF_8000, 0,
                "N16 min*1");
        run_dir(0, 128'hFFFF, 128'hFFFF, 1'b1, 256'h1, 0, "N16 -1*-1");
        run_dir(0, 128'hFFFF, 128'hFFFF, 1'b0, 256'hFFFE_0001, 0,
                "N16 max*max");
        run_dir(0, 128'h1234, 128'h5678, 1'b0, 256'h0626_0060, 10,
                "N16 back-pressure");
        run_dir(1, '1, 128'd5, 1'b1, ~256'h4, 0, "N128 -1*5");
        run_dir(1, {1'b1, 127'b0}, {1'b1, 127'b0}, 1'b1,
                {2'b01, 254'b0}, 0, "N128 min*min");

        ka = 128'hDEAD_BEEF_CAFE_BABE_1234_5678_9ABC_DEF0;
        kb = 128'h0123_4567_89AB_CDEF_DEAD_BEEF_CAFE_BABE;
        run_dir(1, ka, kb, 1'b0, ref_mul(ka, kb, 1'b0, 128), 3,
                "N128 A*B");

        send(0, 128'd7, 128'd9, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(!vo[0] && ro[0] && dq[0] == '0, "reset in MID",
            {vo[0], ro[0], dq[0][31:0]}, {2'b01, 32'h0});
        repeat (8) @(negedge clk);
        run_dir(0, 128'd3, 128'd5, 1'b0, 256'd15, 0, "after reset 3*5");

        left[0] = 5000;
        left[1] = 5000;
        gap[0]  = 0;
        gap[1]  = 0;
        guard   = 0;
        while ((left[0] > 0 || left[1] > 0 || pend != 2'b00)
               && guard < 60000) begin
            @(negedge clk);
            tx = vi & ro;
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (tx[d]) begin
                    vi[d]  = 1'b0;
                    left[d]--;
                    gap[d] = $urandom_range(0, 2);
                    ai[d]  = {$urandom, $urandom, $urandom, $urandom};
                    bi[d]  = {$urandom, $urandom, $urandom, $urandom};
                    sg[d]  = 1'($urandom_range(0, 1));
                end else if (!vi[d] && left[d] > 0) begin
                    if (gap[d] > 0) begin
                        gap[d]--;
                    end else begin
                        vi[d] = 1'b1;
                        ai[d] = rnd_op(d == 1 ? 128 : 16);
                        bi[d] = rnd_op(d == 1 ? 128 : 16);
                        sg[d] = 1'($urandom_range(0, 1));
                    end
                end
                ri[d] = ($urandom_range(0, 3) != 0);
            end
            guard++;
        end
        if (guard >= 60000) chk(1'b0, "random phase timeout", guard, 60000);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/koa_multiplier_seq.md
KOA_MULTIPLIER_SEQ -- requirements
Module: koa_multiplier_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128; operand width N; even, >= 4; half width H = N/2.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; synchronous active-high reset.
REQ-004 SHALL have port mult_a, input, N bits; operand A.
REQ-005 SHALL have port mult_b, input, N bits; operand B.
REQ-006 SHALL have port mult_signed, input, 1 bit; 1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port mult_valid_i, input, 1 bit; operands valid.
REQ-008 SHALL have port mult_ready_o, output, 1 bit; block can accept operands.
REQ-009 SHALL have port mult_d, output, 2N bits; product, held stable while mult_valid_o=1.
REQ-010 SHALL have port mult_valid_o, output, 1 bit; product valid.
REQ-011 SHALL have port mult_ready_i, input, 1 bit; consumer accepts product.

Function
REQ-012 SHALL implement FSM states IDLE, LO, HI, MID, CMB, DONE; one state per cycle, no skipping.
REQ-013 SHALL drive mult_ready_o=1 only in IDLE; input transfer occurs at an edge with mult_valid_i & mult_ready_o; IDLE->LO on transfer, else stay.
REQ-014 SHALL on transfer register mult_signed and magnitudes |A|, |B| (unsigned mode: A, B unchanged), plus result sign sgn = signed & (A[N-1] ^ B[N-1]).
REQ-015 SHALL in LO register P_lo = a_lo*b_lo (2H bits); LO->HI.
REQ-016 SHALL in HI register P_hi = a_hi*b_hi (2H bits); HI->MID.
REQ-017 SHALL in MID register P_mid = (a_lo+a_hi)*(b_lo+b_hi), sums H+1 bits, product 2H+2 bits, no truncation; MID->CMB.
REQ-018 SHALL in CMB compute R = (P_hi<<N) + ((P_mid-P_hi-P_lo)<<H) + P_lo in 2N+2-bit arithmetic, register mult_d = sgn ? -R[2N-1:0] : R[2N-1:0], set mult_valid_o=1; CMB->DONE.
REQ-019 SHALL reuse one (H+1)x(H+1) product unit for all three partial products (operands zero-extended for LO/HI).
REQ-020 SHALL give latency exactly 4 cycles: transfer at edge k -> mult_valid_o high after edge k+4.
REQ-021 SHALL in DONE hold mult_d and mult_valid_o until an edge with mult_ready_i=1, then clear mult_valid_o and go IDLE; back-pressure of any length is legal.
REQ-022 SHALL keep mult_ready_o=0 in DONE even if mult_ready_i=1 (no same-cycle reaccept); min initiation interval 6 cycles.
REQ-023 SHALL ignore mult_a/mult_b/mult_signed/mult_valid_i changes outside the transfer edge.
REQ-024 SHALL handle signed -2^(N-1) as magnitude 2^(N-1) (fits N unsigned bits); (-2^(N-1))^2 = 2^(2N-2) exact.

Reset
REQ-025 SHALL on rst=1 at an edge force IDLE, mult_valid_o=0, mult_d=0, internal products 0, regardless of state; rst has priority over every transfer.
REQ-026 SHALL drive mult_ready_o=1 in the first cycle after rst deasserts; a transaction aborted by reset is discarded, never output.

Structure
REQ-027 SHALL place state enum koa_state_t and width helper constants (H, 2H+2) in package koa_pkg.
REQ-028 SHALL instantiate one sub-module koa_mult_core (combinational, parameter width H+1, 2H+2-bit product) as the shared product unit.

Verification
REQ-029 SHALL check N=128, unsigned, A=B=all ones -> mult_d = 0xFFFF...FE000...01 (2^256-2^129+1), valid 4 cycles after transfer.
REQ-030 SHALL check N=16, signed, A=0x8000, B=0x8000 -> mult_d=0x40000000; A=0x8000, B=0x0001 -> 0xFFFF8000.
REQ-031 SHALL check N=128, A=DEADBEEFCAFEBABE123456789ABCDEF0, B=0123456789ABCDEFDEADBEEFCAFEBABE, unsigned -> equals A*B reference model.
REQ-032 SHALL check back-pressure: mult_ready_i=0 for 10 cycles -> mult_d stable, mult_ready_o=0, single handshake on release, IDLE next cycle.
REQ-033 SHALL check rst asserted in MID -> next cycle IDLE, mult_valid_o=0, mult_d=0, no product emitted; next transaction 3*5=15 correct.
REQ-034 SHALL check 10k random signed/unsigned N=16 and N=128 transactions with random valid/ready gaps against the N x N reference model, zero mismatches.
